// File: rtl/counter_modn_seg7_if.sv
// Switch/display bundle between the lab board and the modulo-N counter.
// The counter side uses the slave modport; the board (or bench) drives through master.
interface counter_modn_seg7_if #(
    parameter int CW = 8
);
    logic          sw_en;
    logic          sw_up;
    logic          sw_load;
    logic [CW-1:0] sw_preset;
    logic          led8_C;
    logic [CW-1:0] count;
    logic [1:0]    num1_scan_select;
    logic [7:0]    num1_seg7;
    logic [1:0]    num2_scan_select;
    logic [7:0]    num2_seg7;

    modport master (
        output sw_en, sw_up, sw_load, sw_preset,
        input  led8_C, count, num1_scan_select, num1_seg7, num2_scan_select, num2_seg7
    );

    modport slave (
        input  sw_en, sw_up, sw_load, sw_preset,
        output led8_C, count, num1_scan_select, num1_seg7, num2_scan_select, num2_seg7
    );
endinterface

// File: rtl/counter_modn_seg7.sv
// Modulo-N up/down counter with clamped preset load, terminal-count LED and two-digit hex display.
// Optional macro BLANK_LEADING_ZERO_EN blanks the high digit while it is zero.
module counter_modn_seg7 #(
    parameter int MODULUS = 13,
    parameter int CW      = 8
) (
    input  logic                 button_clk,
    input  logic                 sw6_reset,
    counter_modn_seg7_if.slave   bus
);
    localparam logic [CW-1:0] MAX_VAL = CW'(MODULUS - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            led_reg;
    logic            led_next;
    logic [1:0]      scan_reg;
    logic [CW-1:0]   term_next;
    logic [7:0]      count_ext;
    logic [1:0][7:0] digit_seg;

    function automatic logic [7:0] hex_font(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'h7E;
            4'h1: s = 8'h30;
            4'h2: s = 8'h6D;
            4'h3: s = 8'h79;
            4'h4: s = 8'h33;
            4'h5: s = 8'h5B;
            4'h6: s = 8'h5F;
            4'h7: s = 8'h70;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h7B;
            4'hA: s = 8'h77;
            4'hB: s = 8'h1F;
            4'hC: s = 8'h4E;
            4'hD: s = 8'h3D;
            4'hE: s = 8'h4F;
            default: s = 8'h47;
        endcase
        return s;
    endfunction

    // Out-of-range counts (only reachable through an upset) recover to 0 on the next count edge.
    always_comb begin
        count_next = count_reg;
        if (bus.sw_load) begin
            count_next = (bus.sw_preset > MAX_VAL) ? MAX_VAL : bus.sw_preset;
        end else if (bus.sw_en) begin
            if (count_reg > MAX_VAL) begin
                count_next = '0;
            end else if (bus.sw_up) begin
                count_next = (count_reg == MAX_VAL) ? '0 : count_reg + ONE;
            end else begin
                count_next = (count_reg == '0) ? MAX_VAL : count_reg - ONE;
            end
        end
    end

    // The LED looks at the value being loaded into count, so it lines up with count exactly.
    assign term_next = bus.sw_up ? MAX_VAL : '0;
    assign led_next  = (count_next == term_next);

    always_ff @(posedge button_clk) begin
        if (sw6_reset) begin
            count_reg <= '0;
            led_reg   <= 1'b0;
            scan_reg  <= 2'b11;
        end else begin
            count_reg <= count_next;
            led_reg   <= led_next;
            scan_reg  <= 2'b10;
        end
    end

    assign count_ext = 8'(count_reg);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            logic [3:0] nibble;
            assign nibble = count_ext[gi*4 +: 4];
            if (gi == 1) begin : g_high
`ifdef BLANK_LEADING_ZERO_EN
                assign digit_seg[gi] = (nibble == 4'h0) ? 8'h00 : hex_font(nibble);
`else
                assign digit_seg[gi] = hex_font(nibble);
`endif
            end else begin : g_low
                assign digit_seg[gi] = hex_font(nibble);
            end
        end
    endgenerate

    assign bus.count            = count_reg;
    assign bus.led8_C           = led_reg;
    assign bus.num1_scan_select = scan_reg;
    assign bus.num2_scan_select = scan_reg;
    assign bus.num1_seg7        = digit_seg[0];
    assign bus.num2_seg7        = digit_seg[1];
endmodule

// File: tb/tb_counter_modn_seg7.sv
// Directed bench for counter_modn_seg7: a MODULUS=13 instance and a MODULUS=200 instance.
module tb_counter_modn_seg7;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] font [16];

    counter_modn_seg7_if #(.CW(8)) b13 ();
    counter_modn_seg7_if #(.CW(8)) b200 ();

    counter_modn_seg7 #(.MODULUS(13), .CW(8)) dut13 (
        .button_clk (clk),
        .sw6_reset  (rst),
        .bus        (b13.slave)
    );

    counter_modn_seg7 #(.MODULUS(200), .CW(8)) dut200 (
        .button_clk (clk),
        .sw6_reset  (rst),
        .bus        (b200.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_hi(input logic [3:0] n);
`ifdef BLANK_LEADING_ZERO_EN
        if (n == 4'h0) return 8'h00;
`endif
        return font[n];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (b13.count !== 8'd0 || b13.led8_C !== 1'b0) begin
            errors++;
            $display("FAIL reset13 count=%0d led=%b expected count=0 led=0", b13.count, b13.led8_C);
        end
        checks++;
        if (b13.num1_scan_select !== 2'b11 || b13.num2_scan_select !== 2'b11 ||
            b200.num1_scan_select !== 2'b11 || b200.num2_scan_select !== 2'b11) begin
            errors++;
            $display("FAIL reset_scan got %b %b %b %b expected all 11", b13.num1_scan_select,
                     b13.num2_scan_select, b200.num1_scan_select, b200.num2_scan_select);
        end
        checks++;
        if (b13.num1_seg7 !== 8'h7E || b13.num2_seg7 !== exp_hi(4'h0)) begin
            errors++;
            $display("FAIL reset_seg got %h %h expected 7e %h", b13.num1_seg7, b13.num2_seg7, exp_hi(4'h0));
        end
        $display("reset: count=%0d led=%b scan=%b", b13.count, b13.led8_C, b13.num1_scan_select);
    endtask

    task automatic test_up();
        int e;
        rst = 1'b0;
        b13.sw_en = 1'b1; b13.sw_up = 1'b1; b13.sw_load = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            e = i % 13;
            checks++;
            if (b13.count !== 8'(e) || b13.led8_C !== (e == 12)) begin
                errors++;
                $display("FAIL up_count edge=%0d count=%0d led=%b expected %0d led=%b",
                         i, b13.count, b13.led8_C, e, (e == 12));
            end
            checks++;
            if (b13.num1_seg7 !== font[e[3:0]] || b13.num1_scan_select !== 2'b10 ||
                b13.num2_scan_select !== 2'b10) begin
                errors++;
                $display("FAIL up_disp edge=%0d seg=%h scan=%b expected seg=%h scan=10",
                         i, b13.num1_seg7, b13.num1_scan_select, font[e[3:0]]);
            end
            $display("up: edge=%0d count=%0d led=%b seg1=%h", i, b13.count, b13.led8_C, b13.num1_seg7);
        end
    endtask

    task automatic test_down();
        int e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b13.sw_en = 1'b1; b13.sw_up = 1'b0; b13.sw_load = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            e = (i % 13 == 0) ? 0 : 13 - (i % 13);
            checks++;
            if (b13.count !== 8'(e) || b13.led8_C !== (e == 0)) begin
                errors++;
                $display("FAIL down_count edge=%0d count=%0d led=%b expected %0d led=%b",
                         i, b13.count, b13.led8_C, e, (e == 0));
            end
            $display("down: edge=%0d count=%0d led=%b", i, b13.count, b13.led8_C);
        end
    endtask

    task automatic test_load();
        b13.sw_en = 1'b1; b13.sw_up = 1'b1; b13.sw_load = 1'b1;
        b13.sw_preset = 8'd5;
        tick();
        checks++;
        if (b13.count !== 8'd5 || b13.led8_C !== 1'b0) begin
            errors++;
            $display("FAIL load5 count=%0d led=%b expected 5 led=0", b13.count, b13.led8_C);
        end
        $display("load: preset=5 count=%0d led=%b", b13.count, b13.led8_C);
        b13.sw_preset = 8'd200;
        tick();
        checks++;
        if (b13.count !== 8'd12 || b13.led8_C !== 1'b1 || b13.num1_seg7 !== 8'h4E) begin
            errors++;
            $display("FAIL load_clamp count=%0d led=%b seg=%h expected 12 led=1 seg=4e",
                     b13.count, b13.led8_C, b13.num1_seg7);
        end
        $display("load: preset=200 count=%0d led=%b", b13.count, b13.led8_C);
    endtask

    task automatic test_hold_and_dir();
        b13.sw_en = 1'b1; b13.sw_up = 1'b1; b13.sw_load = 1'b1; b13.sw_preset = 8'd7;
        tick();
        b13.sw_load = 1'b0; b13.sw_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (b13.count !== 8'd7 || b13.led8_C !== 1'b0) begin
                errors++;
                $display("FAIL hold edge=%0d count=%0d led=%b expected 7 led=0", i, b13.count, b13.led8_C);
            end
            $display("hold: edge=%0d count=%0d led=%b", i, b13.count, b13.led8_C);
        end
        b13.sw_load = 1'b1; b13.sw_preset = 8'd12;
        tick();
        b13.sw_load = 1'b0; b13.sw_en = 1'b1; b13.sw_up = 1'b0;
        tick();
        checks++;
        if (b13.count !== 8'd11 || b13.led8_C !== 1'b0) begin
            errors++;
            $display("FAIL dir_flip count=%0d led=%b expected 11 led=0", b13.count, b13.led8_C);
        end
        $display("dir_flip: count=%0d led=%b", b13.count, b13.led8_C);
    endtask

    task automatic test_mod200();
        b200.sw_en = 1'b1; b200.sw_up = 1'b1; b200.sw_load = 1'b1; b200.sw_preset = 8'h1F;
        tick();
        checks++;
        if (b200.count !== 8'h1F || b200.num1_seg7 !== 8'h47 || b200.num2_seg7 !== 8'h30) begin
            errors++;
            $display("FAIL m200_1f count=%h seg1=%h seg2=%h expected 1f 47 30",
                     b200.count, b200.num1_seg7, b200.num2_seg7);
        end
        b200.sw_load = 1'b0;
        tick();
        checks++;
        if (b200.count !== 8'h20 || b200.num1_seg7 !== 8'h7E || b200.num2_seg7 !== 8'h6D) begin
            errors++;
            $display("FAIL m200_20 count=%h seg1=%h seg2=%h expected 20 7e 6d",
                     b200.count, b200.num1_seg7, b200.num2_seg7);
        end
        $display("m200: count=%h seg2=%h", b200.count, b200.num2_seg7);
        b200.sw_load = 1'b1; b200.sw_preset = 8'h0F;
        tick();
        checks++;
        if (b200.num2_seg7 !== exp_hi(4'h0)) begin
            errors++;
            $display("FAIL m200_0f seg2=%h expected %h", b200.num2_seg7, exp_hi(4'h0));
        end
        b200.sw_load = 1'b0;
        tick();
        checks++;
        if (b200.count !== 8'h10 || b200.num2_seg7 !== 8'h30) begin
            errors++;
            $display("FAIL m200_10 count=%h seg2=%h expected 10 30", b200.count, b200.num2_seg7);
        end
        b200.sw_load = 1'b1; b200.sw_preset = 8'd250;
        tick();
        checks++;
        if (b200.count !== 8'd199 || b200.led8_C !== 1'b1) begin
            errors++;
            $display("FAIL m200_clamp count=%0d led=%b expected 199 led=1", b200.count, b200.led8_C);
        end
        b200.sw_load = 1'b0;
        tick();
        checks++;
        if (b200.count !== 8'd0 || b200.led8_C !== 1'b0 || b200.num2_seg7 !== exp_hi(4'h0)) begin
            errors++;
            $display("FAIL m200_wrap count=%0d led=%b seg2=%h expected 0 led=0 seg2=%h",
                     b200.count, b200.led8_C, b200.num2_seg7, exp_hi(4'h0));
        end
        b200.sw_up = 1'b0;
        tick();
        checks++;
        if (b200.count !== 8'd199 || b200.led8_C !== 1'b0) begin
            errors++;
            $display("FAIL m200_down count=%0d led=%b expected 199 led=0", b200.count, b200.led8_C);
        end
        $display("m200: wrap checks count=%0d led=%b", b200.count, b200.led8_C);
    endtask

    task automatic test_reset_midrun();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b13.sw_en = 1'b1; b13.sw_up = 1'b1; b13.sw_load = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (b13.count !== 8'd9) begin
            errors++;
            $display("FAIL midrun_pre count=%0d expected 9", b13.count);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (b13.count !== 8'd0 || b13.led8_C !== 1'b0 || b13.num1_scan_select !== 2'b11 ||
            b13.num2_scan_select !== 2'b11) begin
            errors++;
            $display("FAIL midrun_reset count=%0d led=%b scan=%b %b expected 0 0 11 11",
                     b13.count, b13.led8_C, b13.num1_scan_select, b13.num2_scan_select);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (b13.count !== 8'd1 || b13.num1_scan_select !== 2'b10) begin
            errors++;
            $display("FAIL midrun_resume count=%0d scan=%b expected 1 10", b13.count, b13.num1_scan_select);
        end
        $display("midrun: count=%0d scan=%b", b13.count, b13.num1_scan_select);
    endtask

    initial begin
        font[0]  = 8'h7E; font[1]  = 8'h30; font[2]  = 8'h6D; font[3]  = 8'h79;
        font[4]  = 8'h33; font[5]  = 8'h5B; font[6]  = 8'h5F; font[7]  = 8'h70;
        font[8]  = 8'h7F; font[9]  = 8'h7B; font[10] = 8'h77; font[11] = 8'h1F;
        font[12] = 8'h4E; font[13] = 8'h3D; font[14] = 8'h4F; font[15] = 8'h47;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        b13.sw_en = 1'b0;  b13.sw_up = 1'b1;  b13.sw_load = 1'b0;  b13.sw_preset = 8'd0;
        b200.sw_en = 1'b0; b200.sw_up = 1'b1; b200.sw_load = 1'b0; b200.sw_preset = 8'd0;
        #2;
        test_reset();
        test_up();
        test_down();
        test_load();
        test_hold_and_dir();
        test_mod200();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
